// File: rtl/clk_en_chain_pkg.sv
// +--------------------------------------------------------------------+
// | clk_en_chain_pkg                                                   |
// | Shared defaults and limits for the clock enable chain.             |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package clk_en_chain_pkg;

   localparam int c_NUM_STAGES_DEF = 4;
   localparam int c_CNT_WIDTH_DEF  = 12;
   localparam int c_MAX_STAGES     = 8;
   localparam int c_SEL_WIDTH      = 3;

   // Stage 0 lives in the LSBs: /2, /10, /100, /1000.
   localparam logic [c_NUM_STAGES_DEF*c_CNT_WIDTH_DEF-1:0] c_DIV_INIT_DEF =
      {12'd1000, 12'd100, 12'd10, 12'd2};

endpackage

`default_nettype wire

// File: rtl/clock_enable_stage.sv
// +--------------------------------------------------------------------+
// | clock_enable_stage                                                 |
// | One divider stage: counter, pending divider register, wrap logic.  |
// | Optional toggle output built only with CLK_EN_CHAIN_TOGGLE_EN.     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module clock_enable_stage
   import clk_en_chain_pkg::*;
#(
   parameter int                   CNT_WIDTH = c_CNT_WIDTH_DEF,
   parameter logic [CNT_WIDTH-1:0] DIV_RST   = CNT_WIDTH'(2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   input  logic                 i_clr,
   input  logic                 i_wr,
   input  logic [CNT_WIDTH-1:0] i_data,
   output logic                 o_wrap,
   output logic                 o_tick,
   output logic                 o_toggle,
   output logic                 o_pend
);

   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_div;
   logic [CNT_WIDTH-1:0] r_pend_val;
   logic                 r_pend;
   logic                 r_tick;
   logic [CNT_WIDTH-1:0] w_div_eff;
   logic [CNT_WIDTH-1:0] w_div_next;
   logic                 w_wrap;

   // A zero divider behaves as divide-by-one.
   assign w_div_eff  = (r_div == '0) ? CNT_WIDTH'(1) : r_div;
   assign w_wrap     = i_en & ~i_clr & (r_cnt == (w_div_eff - CNT_WIDTH'(1)));
   // A write landing on the apply cycle wins over an older pending value.
   assign w_div_next = i_wr ? i_data : (r_pend ? r_pend_val : r_div);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_wrap ? '0 : (r_cnt + CNT_WIDTH'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div      <= DIV_RST;
         r_pend_val <= '0;
         r_pend     <= 1'b0;
      end else if (i_clr || w_wrap) begin
         r_div  <= w_div_next;
         r_pend <= 1'b0;
      end else if (i_wr) begin
         r_pend_val <= i_data;
         r_pend     <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
      end
   end

`ifdef CLK_EN_CHAIN_TOGGLE_EN
   logic r_toggle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_toggle <= 1'b0;
      end else if (i_clr) begin
         r_toggle <= 1'b0;
      end else if (w_wrap) begin
         r_toggle <= ~r_toggle;
      end
   end

   assign o_toggle = r_toggle;
`else
   assign o_toggle = 1'b0;
`endif

   assign o_wrap = w_wrap;
   assign o_tick = r_tick;
   assign o_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/clock_enable_chain.sv
// +--------------------------------------------------------------------+
// | clock_enable_chain                                                 |
// | Cascade of NUM_STAGES programmable clock-enable dividers.          |
// | Define CLK_EN_CHAIN_TOGGLE_EN to build the 50% toggle outputs.     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module clock_enable_chain
   import clk_en_chain_pkg::*;
#(
   parameter int                                 NUM_STAGES = c_NUM_STAGES_DEF,
   parameter int                                 CNT_WIDTH  = c_CNT_WIDTH_DEF,
   parameter logic [NUM_STAGES*CNT_WIDTH-1:0]    DIV_INIT   = c_DIV_INIT_DEF
) (
   input  logic                   CLK_IN,
   input  logic                   RESET_N,
   input  logic                   RUN,
   input  logic                   SYNC_CLR,
   input  logic                   DIV_WR,
   input  logic [c_SEL_WIDTH-1:0] DIV_SEL,
   input  logic [CNT_WIDTH-1:0]   DIV_DATA,
   output logic [NUM_STAGES-1:0]  TICK_O,
   output logic [NUM_STAGES-1:0]  TOGGLE_O,
   output logic [NUM_STAGES-1:0]  PEND_O
);

   // w_en[i] enables stage i; w_en[i+1] is stage i's wrap.
   logic [NUM_STAGES:0] w_en;
   logic                w_unused_wrap;

   assign w_en[0]       = RUN;
   assign w_unused_wrap = w_en[NUM_STAGES];

   generate
      for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         logic w_wr;

         // Selects beyond the last stage match no instance and are dropped.
         assign w_wr = DIV_WR && (DIV_SEL == c_SEL_WIDTH'(gi));

         clock_enable_stage #(
            .CNT_WIDTH (CNT_WIDTH),
            .DIV_RST   (DIV_INIT[gi*CNT_WIDTH +: CNT_WIDTH])
         ) u_stage (
            .clk      (CLK_IN),
            .rst_n    (RESET_N),
            .i_en     (w_en[gi]),
            .i_clr    (SYNC_CLR),
            .i_wr     (w_wr),
            .i_data   (DIV_DATA),
            .o_wrap   (w_en[gi+1]),
            .o_tick   (TICK_O[gi]),
            .o_toggle (TOGGLE_O[gi]),
            .o_pend   (PEND_O[gi])
         );
      end
   endgenerate

endmodule

`default_nettype wire
